cdb_arbiter: RTL and testbench

Writeback arbiter that shares the single common data bus (CDB) among the ALU, MUL and LSU functional units. Each unit pushes completed results (physical destination tag plus 32-bit value) into a private per-unit queue with a valid/ready handshake. One entry per cycle is selected and driven onto a registered CDB. The CDB supplies `wb_en`, `wb_reg_addr` and `wb_data` to the rename wakeup, the reorder buffer and the register file.

---
 rtl/cdb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// -----------
// Writeback arbiter for the common data bus. The ALU, MUL and LSU each push
// completed results (destination tag + value) into a private circular FIFO.
// Each cycle one non-empty FIFO is selected, its head is popped and loaded
// into the registered CDB output, which feeds rename wakeup, the ROB and the
// register file. The consumer never backpressures; a broadcast lasts one cycle.
//
// Ports:
//   clk_i, reset_i (async, active-low), flush_i (sync discard of all results)
//   alu_/mul_/lsu_ valid_i, tag_i, data_i   : producer push side
//   alu_/mul_/lsu_ ready_o                  : queue not full (registered state only)
//   cdb_valid_o, cdb_tag_o, cdb_data_o      : registered broadcast
//   cdb_src_o                               : 0 = ALU, 1 = MUL, 2 = LSU
//
// Build option:
//   CDB_ROUND_ROBIN_EN defined   -> round-robin grant starting after last winner
//   CDB_ROUND_ROBIN_EN undefined -> fixed priority LSU > MUL > ALU
module cdb_arbiter #(
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              alu_valid_i,
   input  logic [TAG_W-1:0]  alu_tag_i,
   input  logic [DATA_W-1:0] alu_data_i,
   output logic              alu_ready_o,
   input  logic              mul_valid_i,
   input  logic [TAG_W-1:0]  mul_tag_i,
   input  logic [DATA_W-1:0] mul_data_i,
   output logic              mul_ready_o,
   input  logic              lsu_valid_i,
   input  logic [TAG_W-1:0]  lsu_tag_i,
   input  logic [DATA_W-1:0] lsu_data_i,
   output logic              lsu_ready_o,
   output logic              cdb_valid_o,
   output logic [TAG_W-1:0]  cdb_tag_o,
   output logic [DATA_W-1:0] cdb_data_o,
   output logic [1:0]        cdb_src_o
);

   localparam int NSRC  = 3;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int EW    = TAG_W + DATA_W;

   logic [NSRC-1:0] in_valid;
   logic [EW-1:0]   in_entry [NSRC];
   logic [EW-1:0]   head     [NSRC];
   logic [NSRC-1:0] ready;
   logic [NSRC-1:0] not_empty;
   logic [NSRC-1:0] push;
   logic [NSRC-1:0] pop;

   logic            grant_any;
   logic [1:0]      grant_idx;

   assign in_valid    = {lsu_valid_i, mul_valid_i, alu_valid_i};
   assign in_entry[0] = {alu_tag_i, alu_data_i};
   assign in_entry[1] = {mul_tag_i, mul_data_i};
   assign in_entry[2] = {lsu_tag_i, lsu_data_i};

   assign alu_ready_o = ready[0];
   assign mul_ready_o = ready[1];
   assign lsu_ready_o = ready[2];

   // Per-source circular FIFOs. DEPTH is a power of two, so the pointers wrap
   // by natural overflow. Queues are shallow, so the head is read directly and
   // the CDB output register acts as the read register.
   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : gen_queue
         logic [EW-1:0]    mem [DEPTH];
         logic [PTR_W-1:0] wr_ptr_reg;
         logic [PTR_W-1:0] rd_ptr_reg;
         logic [CNT_W-1:0] count_reg;

         // Ready comes from the registered count only: a full queue stays
         // not-ready even in a cycle where it is being popped.
         assign ready[gi]     = (count_reg != CNT_W'(DEPTH));
         assign not_empty[gi] = (count_reg != '0);
         assign head[gi]      = mem[rd_ptr_reg];
         assign push[gi]      = in_valid[gi] & ready[gi] & ~flush_i;
         assign pop[gi]       = grant_any & (grant_idx == 2'(gi)) & ~flush_i;

         always_ff @(posedge clk_i) begin
            if (push[gi]) begin
               mem[wr_ptr_reg] <= in_entry[gi];
            end
         end

         always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else if (flush_i) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push[gi]) begin
                  wr_ptr_reg <= wr_ptr_reg + 1'b1;
               end
               if (pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + 1'b1;
               end
               case ({push[gi], pop[gi]})
                  2'b10:   count_reg <= count_reg + 1'b1;
                  2'b01:   count_reg <= count_reg - 1'b1;
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

`ifdef CDB_ROUND_ROBIN_EN
   logic [1:0] rr_ptr_reg;
   int         cand;

   // Scan upward from the source after the last winner, wrapping mod 3.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = 2'd0;
      cand      = 0;
      for (int k = 1; k <= NSRC; k++) begin
         cand = (int'(rr_ptr_reg) + k) % NSRC;
         if (!grant_any && not_empty[cand]) begin
            grant_any = 1'b1;
            grant_idx = 2'(cand);
         end
      end
   end

   // Reset value LSU makes ALU the first candidate.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rr_ptr_reg <= 2'd2;
      end else if (!flush_i && grant_any) begin
         rr_ptr_reg <= grant_idx;
      end
   end
`else
   always_comb begin
      grant_any = 1'b0;
      grant_idx = 2'd0;
      if (not_empty[2]) begin
         grant_any = 1'b1;
         grant_idx = 2'd2;
      end else if (not_empty[1]) begin
         grant_any = 1'b1;
         grant_idx = 2'd1;
      end else if (not_empty[0]) begin
         grant_any = 1'b1;
         grant_idx = 2'd0;
      end
   end
`endif

   // Registered CDB. Tag/data/src hold their last values when idle.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cdb_valid_o <= 1'b0;
         cdb_tag_o   <= '0;
         cdb_data_o  <= '0;
         cdb_src_o   <= 2'd0;
      end else if (flush_i) begin
         cdb_valid_o <= 1'b0;
      end else if (grant_any) begin
         cdb_valid_o <= 1'b1;
         cdb_tag_o   <= head[grant_idx][EW-1:DATA_W];
         cdb_data_o  <= head[grant_idx][DATA_W-1:0];
         cdb_src_o   <= grant_idx;
      end else begin
         cdb_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// --------------
// Randomized and directed stimulus for cdb_arbiter. A queue-level reference
// model predicts each broadcast and pushes it into a scoreboard; a monitor on
// the falling edge pops and compares whatever the CDB presents, and also
// checks the ready outputs against the model's queue occupancy.
module tb_cdb_arbiter;

   localparam int DEPTH  = 2;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int EW     = TAG_W + DATA_W;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic flush   = 1'b0;

   always #5 clk = ~clk;

   logic              src_valid [3];
   logic [TAG_W-1:0]  src_tag   [3];
   logic [DATA_W-1:0] src_data  [3];
   logic [2:0]        rdy;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic [1:0]        cdb_src;

   cdb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk_i       (clk),
      .reset_i     (reset_n),
      .flush_i     (flush),
      .alu_valid_i (src_valid[0]),
      .alu_tag_i   (src_tag[0]),
      .alu_data_i  (src_data[0]),
      .alu_ready_o (rdy[0]),
      .mul_valid_i (src_valid[1]),
      .mul_tag_i   (src_tag[1]),
      .mul_data_i  (src_data[1]),
      .mul_ready_o (rdy[1]),
      .lsu_valid_i (src_valid[2]),
      .lsu_tag_i   (src_tag[2]),
      .lsu_data_i  (src_data[2]),
      .lsu_ready_o (rdy[2]),
      .cdb_valid_o (cdb_valid),
      .cdb_tag_o   (cdb_tag),
      .cdb_data_o  (cdb_data),
      .cdb_src_o   (cdb_src)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   logic [EW-1:0]   mq [3][$];
   logic [EW+1:0]   exp_q [$];
   bit              acc [3];
   bit              room [3];
   int              rr;
   int              g;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < 3; s++) begin
            mq[s].delete();
            acc[s] = 1'b0;
         end
         exp_q.delete();
         rr = 2;
      end else begin
         for (int s = 0; s < 3; s++) room[s] = (mq[s].size() != DEPTH);
         if (flush) begin
            for (int s = 0; s < 3; s++) begin
               mq[s].delete();
               acc[s] = 1'b0;
            end
         end else begin
            g = -1;
`ifdef CDB_ROUND_ROBIN_EN
            for (int k = 1; k <= 3; k++)
               if (g < 0 && mq[(rr + k) % 3].size() > 0) g = (rr + k) % 3;
`else
            for (int s = 2; s >= 0; s--)
               if (g < 0 && mq[s].size() > 0) g = s;
`endif
            if (g >= 0) begin
               exp_q.push_back({2'(g), mq[g][0]});
               void'(mq[g].pop_front());
               rr = g;
            end
            for (int s = 0; s < 3; s++) begin
               acc[s] = src_valid[s] && room[s];
               if (acc[s]) mq[s].push_back({src_tag[s], src_data[s]});
            end
         end
      end
   end

   // ---------------- monitor ----------------
   logic [EW+1:0] e;
   always @(negedge clk) begin
      if (reset_n) begin
         for (int s = 0; s < 3; s++)
            check($sformatf("ready%0d", s), 64'(rdy[s]), 64'(mq[s].size() != DEPTH));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cdb_valid", 64'(cdb_valid), 64'(1));
            if (cdb_valid)
               check($sformatf("cdb_word src%0d tag%0d", e[EW+1:EW], e[EW-1:DATA_W]),
                     64'({cdb_src, cdb_tag, cdb_data}), 64'(e));
         end else begin
            check("cdb_idle", 64'(cdb_valid), 64'(0));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++)
         if (src_valid[s] && acc[s]) src_valid[s] = 1'b0;
   endtask

   task automatic offer(input int s, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      if (!src_valid[s]) begin
         src_valid[s] = 1'b1;
         src_tag[s]   = t;
         src_data[s]  = d;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(cdb_valid), 64'(0));
      check({tag, "_tag"},   64'(cdb_tag),   64'(0));
      check({tag, "_data"},  64'(cdb_data),  64'(0));
      check({tag, "_src"},   64'(cdb_src),   64'(0));
      check({tag, "_ready"}, 64'(rdy),       64'(3'b111));
   endtask

   bit saw_mul_low;
   int mt;

   initial begin
      for (int s = 0; s < 3; s++) begin
         src_valid[s] = 1'b0;
         src_tag[s]   = '0;
         src_data[s]  = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;

      // single ALU push
      offer(0, 5'd5, 32'h0000_00AA);
      tick();
      repeat (3) tick();

      // three-way contention
      offer(0, 5'd1, 32'h111);
      offer(1, 5'd2, 32'h222);
      offer(2, 5'd3, 32'h333);
      tick();
      repeat (4) tick();

      // MUL fills while LSU streams
      saw_mul_low = 1'b0;
      mt = 10;
      for (int c = 0; c < 6; c++) begin
         offer(2, 5'(20 + c), $urandom);
         if (!src_valid[1] && mt < 14) begin
            offer(1, 5'(mt), $urandom);
            mt++;
         end
         tick();
         if (!rdy[1]) saw_mul_low = 1'b1;
      end
      for (int c = 0; c < 8; c++) begin
         if (!src_valid[1] && mt < 14) begin
            offer(1, 5'(mt), $urandom);
            mt++;
         end
         tick();
      end
`ifndef CDB_ROUND_ROBIN_EN
      check("mul_ready_dropped", 64'(saw_mul_low), 64'(1));
`endif

      // ALU wrap-around stream
      for (int i = 0; i < 10; i++) begin
         offer(0, 5'(i), 32'(i * 3 + 1));
         tick();
      end
      repeat (3) tick();

      // flush with entries queued
      for (int c = 0; c < 2; c++) begin
         for (int s = 0; s < 3; s++) offer(s, 5'(28 + s), $urandom);
         tick();
      end
      for (int s = 0; s < 3; s++) offer(s, 5'(25 + s), $urandom);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int s = 0; s < 3; s++) src_valid[s] = 1'b0;
      check("flush_ready", 64'(rdy), 64'(3'b111));
      check("flush_cdb_valid", 64'(cdb_valid), 64'(0));
      repeat (4) tick();

      // asynchronous reset mid-stream
      for (int c = 0; c < 3; c++) begin
         offer(2, 5'(16 + c), $urandom);
         offer(1, 5'(12 + c), $urandom);
         tick();
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      for (int s = 0; s < 3; s++) src_valid[s] = 1'b0;
      #10;
      reset_n = 1'b1;
      repeat (4) tick();

      // randomized traffic with occasional flush
      for (int c = 0; c < 1500; c++) begin
         for (int s = 0; s < 3; s++)
            if ($urandom_range(0, 3) != 0) offer(s, 5'($urandom), $urandom);
         flush = ($urandom_range(0, 99) == 0);
         tick();
         flush = 1'b0;
      end
      for (int s = 0; s < 3; s++) src_valid[s] = 1'b0;
      repeat (10) tick();
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
